// File: rtl/sram_pkg.sv
// Shared types and sizes for the two-port SRAM arbiter.
package sram_pkg;
  localparam int unsigned SRAM_AW   = 20;
  localparam int unsigned SRAM_DW   = 16;
  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  // Request fields frozen at the arbitration decision
  typedef struct packed {
    logic               we;
    logic               ub;
    logic               lb;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_req_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-port requests in, ack/rdata/busy out.
interface sram_arbiter_if;
  import sram_pkg::*;

  logic [NUM_PORTS-1:0]              req;
  logic [NUM_PORTS-1:0]              req_we;
  logic [NUM_PORTS-1:0]              req_ub;
  logic [NUM_PORTS-1:0]              req_lb;
  logic [NUM_PORTS-1:0][SRAM_AW-1:0] req_addr;
  logic [NUM_PORTS-1:0][SRAM_DW-1:0] req_wdata;
  logic [NUM_PORTS-1:0]              ack;
  logic [SRAM_DW-1:0]                rdata;
  logic                              busy;

  modport master (
    output req, req_we, req_ub, req_lb, req_addr, req_wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, req_we, req_ub, req_lb, req_addr, req_wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for an asynchronous 16-bit SRAM.
// All SRAM strobes are registered and follow the next FSM state.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_arbiter_if.slave      bus,
  output logic               ce,
  output logic               ub,
  output logic               lb,
  output logic               oe,
  output logic               we,
  output logic [SRAM_AW-1:0] a,
  inout  wire  [SRAM_DW-1:0] data
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > (2**CNT_W - 1)) begin : g_bad_access_cycles
    $error("sram_arbiter: ACCESS_CYCLES must be within 1..15");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 winner;
  sram_req_t            lat_q, lat_d;
  logic [SRAM_DW-1:0]   rdata_d;
  logic [NUM_PORTS-1:0] ack_d;
  logic                 ce_d, ub_d, lb_d, oe_d, we_d, busy_d;
  logic                 drive_q, drive_d;
  logic [SRAM_AW-1:0]   a_d;

  // Contention goes to the port not granted last time
  always_comb begin
    winner = 1'b0;
    if (&bus.req)        winner = ~last_q;
    else if (bus.req[1]) winner = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    lat_d   = lat_q;
    rdata_d = bus.rdata;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d     = ST_SETUP;
          grant_d     = winner;
          last_d      = winner;
          lat_d.we    = bus.req_we[winner];
          lat_d.ub    = bus.req_ub[winner];
          lat_d.lb    = bus.req_lb[winner];
          lat_d.addr  = bus.req_addr[winner];
          lat_d.wdata = bus.req_wdata[winner];
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == CNT_W'(ACCESS_CYCLES - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          if (!lat_q.we) rdata_d = data;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pin values are registered, so they are derived from the state being entered
    busy_d  = (state_d != ST_IDLE);
    ce_d    = ~busy_d;
    ub_d    = busy_d ? ~lat_d.ub : 1'b1;
    lb_d    = busy_d ? ~lat_d.lb : 1'b1;
    oe_d    = !((state_d == ST_STROBE) && !lat_d.we);
    we_d    = !((state_d == ST_STROBE) && lat_d.we);
    a_d     = lat_d.addr;
    drive_d = busy_d && lat_d.we;
    ack_d   = '0;
    if (state_d == ST_HOLD) ack_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      lat_q     <= '0;
      drive_q   <= 1'b0;
      ce        <= 1'b1;
      ub        <= 1'b1;
      lb        <= 1'b1;
      oe        <= 1'b1;
      we        <= 1'b1;
      a         <= '0;
      bus.ack   <= '0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      lat_q     <= lat_d;
      drive_q   <= drive_d;
      ce        <= ce_d;
      ub        <= ub_d;
      lb        <= lb_d;
      oe        <= oe_d;
      we        <= we_d;
      a         <= a_d;
      bus.ack   <= ack_d;
      bus.rdata <= rdata_d;
      bus.busy  <= busy_d;
    end
  end

  assign data = drive_q ? lat_q.wdata : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pin model, transaction-level reference memory and round-robin model.
`timescale 1ns/1ps
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int unsigned ACC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // DUT instances: main (ACC=2) plus two period probes (1 and 15)
  sram_arbiter_if bus();
  sram_arbiter_if bus1();
  sram_arbiter_if bus15();

  logic ce, ub, lb, oe, we;          logic [19:0] a;   wire [15:0] data;
  logic ce1, ub1, lb1, oe1, we1;     logic [19:0] a1;  wire [15:0] data1;
  logic ce15, ub15, lb15, oe15, we15; logic [19:0] a15; wire [15:0] data15;

  sram_arbiter #(.ACCESS_CYCLES(ACC)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ce(ce), .ub(ub), .lb(lb), .oe(oe), .we(we), .a(a), .data(data));
  sram_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .ce(ce1), .ub(ub1), .lb(lb1), .oe(oe1), .we(we1), .a(a1), .data(data1));
  sram_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .bus(bus15),
    .ce(ce15), .ub(ub15), .lb(lb15), .oe(oe15), .we(we15), .a(a15), .data(data15));

  // Asynchronous SRAM pin model (256 words, address aliased on a[7:0])
  logic [15:0] mem [256];
  pullup (data);
  pullup (data1);
  pullup (data15);
  assign data   = (!ce && !oe)     ? mem[a[7:0]]   : 16'hzzzz;
  assign data1  = (!ce1 && !oe1)   ? mem[a1[7:0]]  : 16'hzzzz;
  assign data15 = (!ce15 && !oe15) ? mem[a15[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce && !we) begin
      if (!ub) mem[a[7:0]][15:8] = data[15:8];
      if (!lb) mem[a[7:0]][7:0]  = data[7:0];
    end
  end

  // Reference model: word memory updated per completed transaction, round-robin pointer
  logic [15:0] ref_mem [256];
  int rr_last = 1;

  task automatic ref_write(input logic [19:0] ad, input logic [15:0] wd, input logic u, input logic l);
    if (u) ref_mem[ad[7:0]][15:8] = wd[15:8];
    if (l) ref_mem[ad[7:0]][7:0]  = wd[7:0];
  endtask

  // Pin monitor for the main instance
  int oe_cnt = 0, we_cnt = 0;
  logic [19:0] strobe_a;
  logic s_ub, s_lb, prev_we = 1'b1, prev_ce = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_exclusive", 32'(bus.ack == 2'b11), 32'd0);
      chk("oe_we_exclusive", 32'(!oe && !we), 32'd0);
      if (!we && prev_we) chk("we_after_setup", 32'(prev_ce), 32'd0);
      if (!oe) oe_cnt++;
      if (!we) we_cnt++;
      if (!oe || !we) begin strobe_a = a; s_ub = ub; s_lb = lb; end
      prev_we = we; prev_ce = ce;
    end else begin
      prev_we = 1'b1; prev_ce = 1'b1;
    end
  end

  // Period monitors for the ACCESS_CYCLES=1/15 instances
  int unsigned last1 = 0, per1 = 0, last15 = 0, per15 = 0;
  int n1 = 0, n15 = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("oe_we_excl_1", 32'(!oe1 && !we1), 32'd0);
      chk("oe_we_excl_15", 32'(!oe15 && !we15), 32'd0);
      if (bus1.ack[0]) begin
        per1 = cyc - last1; last1 = cyc; n1++;
        chk("rdata_ac1", 32'(bus1.rdata), 32'h3A5C);
      end
      if (bus15.ack[0]) begin
        per15 = cyc - last15; last15 = cyc; n15++;
        chk("rdata_ac15", 32'(bus15.rdata), 32'h3A5C);
      end
    end
  end

  task automatic set_port(input int p, input logic wr, input logic u, input logic l,
                          input logic [19:0] ad, input logic [15:0] wd);
    bus.req_we[p] = wr; bus.req_ub[p] = u; bus.req_lb[p] = l;
    bus.req_addr[p] = ad; bus.req_wdata[p] = wd;
  endtask

  task automatic rand_port(input int p);
    set_port(p, 1'($urandom), 1'($urandom), 1'($urandom),
             {12'($urandom), 8'($urandom_range(8'h60, 8'hEF))}, 16'($urandom));
  endtask

  // Waits for any ack, counting rising edges; returns edge count (budget-bounded)
  task automatic wait_ack(output int edges);
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk);
    end while (bus.ack == 2'b00 && edges < 40);
  endtask

  // One isolated access on port p, checked against the reference model
  task automatic run_single(input int p, input logic wr, input logic u, input logic l,
                            input logic [19:0] ad, input logic [15:0] wd, input string tag);
    int edges;
    @(negedge clk);
    set_port(p, wr, u, l, ad, wd);
    oe_cnt = 0; we_cnt = 0;
    bus.req[p] = 1'b1;
    wait_ack(edges);
    chk({tag, "_latency"}, 32'(edges), 32'(ACC + 2));
    chk({tag, "_ack"}, 32'(bus.ack), 32'(1 << p));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (!wr) chk({tag, "_rdata"}, 32'(bus.rdata), 32'(ref_mem[ad[7:0]]));
    else ref_write(ad, wd, u, l);
    chk({tag, "_oe_width"}, 32'(oe_cnt), wr ? 32'd0 : 32'(ACC));
    chk({tag, "_we_width"}, 32'(we_cnt), wr ? 32'(ACC) : 32'd0);
    chk({tag, "_addr"}, 32'(strobe_a), 32'(ad));
    chk({tag, "_ub_lb"}, 32'({s_ub, s_lb}), 32'({~u, ~l}));
    rr_last = p;
    bus.req[p] = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_one_cycle"}, 32'(bus.ack), 32'd0);
  endtask

  initial begin
    int edges, exp_p;
    logic seen_ack;
    logic [15:0] v;

    rst_n = 1'b0;
    bus.req = '0; bus.req_we = '0; bus.req_ub = '0; bus.req_lb = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus1.req = '0; bus1.req_we = '0; bus1.req_ub = 2'b11; bus1.req_lb = 2'b11;
    bus1.req_addr = '0; bus1.req_wdata = '0;
    bus15.req = '0; bus15.req_we = '0; bus15.req_ub = 2'b11; bus15.req_lb = 2'b11;
    bus15.req_addr = '0; bus15.req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom); mem[i] = v; ref_mem[i] = v;
    end
    mem[8'h10] = 16'h3A5C; ref_mem[8'h10] = 16'h3A5C;
    mem[8'hFF] = 16'h1234; ref_mem[8'hFF] = 16'h1234;
    mem[8'h20] = 16'hC0DE; ref_mem[8'h20] = 16'hC0DE;
    mem[8'h30] = 16'h1111; ref_mem[8'h30] = 16'h1111;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({ce, ub, lb, oe, we}), 32'h1F);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_data_hiz", 32'(data), 32'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // CPU read and aux partial write
    run_single(0, 1'b0, 1'b1, 1'b1, 20'h00010, 16'h0000, "cpu_read");
    run_single(1, 1'b1, 1'b1, 1'b0, 20'hFFFFF, 16'hBEEF, "aux_write");
    chk("aux_write_upper_only", 32'(mem[8'hFF]), 32'hBE34);
    chk("aux_write_hiz_after", 32'(data), 32'hFFFF);
    run_single(1, 1'b0, 1'b0, 1'b0, 20'hFFFFF, 16'h0000, "aux_readback");

    // Continuous contention: grants must alternate starting with the CPU
    @(negedge clk);
    rand_port(0); rand_port(1);
    bus.req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      exp_p = 1 - rr_last;
      wait_ack(edges);
      chk("rr_latency", 32'(edges), 32'(ACC + 2));
      chk("rr_grant", 32'(bus.ack), 32'(1 << exp_p));
      if (!bus.req_we[exp_p])
        chk("rr_rdata", 32'(bus.rdata), 32'(ref_mem[bus.req_addr[exp_p][7:0]]));
      else
        ref_write(bus.req_addr[exp_p], bus.req_wdata[exp_p], bus.req_ub[exp_p], bus.req_lb[exp_p]);
      rr_last = exp_p;
      rand_port(exp_p);
      @(negedge clk);
      chk("rr_ack_one_cycle", 32'(bus.ack), 32'd0);
    end
    bus.req = 2'b00;
    for (int i = 8'h60; i <= 8'hEF; i += 29)
      run_single(0, 1'b0, 1'b1, 1'b1, 20'(i), 16'h0000, "rr_mem_scan");

    // Reset during the strobe of a write
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 1'b1, 20'h00055, 16'hA5A5);
    bus.req[0] = 1'b1;
    edges = 0;
    do begin @(negedge clk); edges++; end while (we && edges < 20);
    chk("rst_mid_reached_strobe", 32'(we), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", 32'({ce, oe, we}), 32'h7);
    chk("rst_mid_data_hiz", 32'(data), 32'hFFFF);
    chk("rst_mid_ack", 32'(bus.ack), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_last = 1;
    seen_ack = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.ack != 2'b00) seen_ack = 1'b1; end
    chk("rst_mid_no_ack", 32'(seen_ack), 32'd0);
    run_single(0, 1'b0, 1'b1, 1'b1, 20'h00010, 16'h0000, "post_rst_read");

    // Requester changes address and drops req during the strobe
    @(negedge clk);
    set_port(1, 1'b0, 1'b1, 1'b1, 20'h00020, 16'h0000);
    bus.req[1] = 1'b1;
    edges = 0;
    do begin @(negedge clk); edges++; end while (oe && edges < 20);
    bus.req_addr[1] = 20'h00030;
    bus.req[1] = 1'b0;
    wait_ack(edges);
    chk("drop_ack", 32'(bus.ack), 32'b10);
    chk("drop_rdata", 32'(bus.rdata), 32'(ref_mem[8'h20]));
    chk("drop_addr", 32'(a), 32'h00020);
    rr_last = 1;

    // Back-to-back read periods at ACCESS_CYCLES 1 and 15
    @(negedge clk);
    bus1.req_addr[0] = 20'h00010; bus15.req_addr[0] = 20'h00010;
    bus1.req[0] = 1'b1; bus15.req[0] = 1'b1;
    repeat (4 * 18 + 6) @(negedge clk);
    bus1.req[0] = 1'b0; bus15.req[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("period_ac1", 32'(per1), 32'd4);
    chk("period_ac15", 32'(per15), 32'd18);
    chk("acks_ac1_enough", 32'(n1 >= 3), 32'd1);
    chk("acks_ac15_enough", 32'(n15 >= 3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
